// File: rtl/vend_coin_ctrl.sv
// Vending coin front-end: buffers coin events, accumulates credit in nickels,
// sequences the product dispense pulse and pays change or refunds as timed ejector pulses.
module vend_coin_ctrl #(
  parameter int unsigned PRICE      = 3,
  parameter int unsigned MAX_CREDIT = 20,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned PAY_GAP    = 2,
  localparam int unsigned CW        = $clog2(MAX_CREDIT + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          coin_valid,
  input  logic [1:0]    coin_type,
  output logic          coin_ready,
  input  logic          refund_req,
  output logic          dispense,
  output logic          coin_reject,
  output logic          pay_dime,
  output logic          pay_nickel,
  output logic [CW-1:0] credit,
  output logic          busy
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned GW = $clog2(PAY_GAP + 1);
  // One bit of headroom over credit, and never too narrow to hold a quarter (5).
  localparam int unsigned SW = (CW + 1 > 3) ? CW + 1 : 3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_VEND,
    S_PAYOUT
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] credit_nxt;
  logic [GW-1:0] gap_cnt, gap_nxt;
  logic          dispense_nxt, reject_nxt, dime_nxt, nickel_nxt, busy_nxt;

  logic [1:0]    mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          full, empty, push, pop;
  logic [1:0]    head;
  logic [SW-1:0] coin_val, sum, after_vend;

  // Coin event FIFO; pointers carry an extra wrap bit to tell full from empty.
  assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty      = (wr_ptr == rd_ptr);
  assign coin_ready = !full;
  assign push       = coin_valid && coin_ready && (coin_type != 2'b00);
  assign head       = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW + 1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW + 1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= coin_type;
  end

  always_comb begin
    coin_val = '0;
    case (head)
      2'b01:   coin_val = SW'(1);
      2'b10:   coin_val = SW'(2);
      2'b11:   coin_val = SW'(5);
      default: coin_val = '0;
    endcase
  end

  assign sum        = SW'(credit) + coin_val;
  assign after_vend = SW'(credit) - SW'(PRICE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      credit      <= '0;
      gap_cnt     <= '0;
      dispense    <= 1'b0;
      coin_reject <= 1'b0;
      pay_dime    <= 1'b0;
      pay_nickel  <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      credit      <= credit_nxt;
      gap_cnt     <= gap_nxt;
      dispense    <= dispense_nxt;
      coin_reject <= reject_nxt;
      pay_dime    <= dime_nxt;
      pay_nickel  <= nickel_nxt;
      busy        <= busy_nxt;
    end
  end

  // Pulse outputs are computed one cycle ahead so they appear registered.
  always_comb begin
    state_nxt    = state;
    credit_nxt   = credit;
    gap_nxt      = gap_cnt;
    dispense_nxt = 1'b0;
    reject_nxt   = 1'b0;
    dime_nxt     = 1'b0;
    nickel_nxt   = 1'b0;
    pop          = 1'b0;

    case (state)
      S_IDLE: begin
        if (refund_req && (credit != '0)) begin
          state_nxt  = S_PAYOUT;
          gap_nxt    = '0;
          dime_nxt   = (SW'(credit) >= SW'(2));
          nickel_nxt = (SW'(credit) <  SW'(2));
        end else if (!empty) begin
          pop = 1'b1;
          if (sum > SW'(MAX_CREDIT)) begin
            reject_nxt = 1'b1;
          end else begin
            credit_nxt = CW'(sum);
            if (sum >= SW'(PRICE)) begin
              state_nxt    = S_VEND;
              dispense_nxt = 1'b1;
            end
          end
        end
      end

      S_VEND: begin
        credit_nxt = CW'(after_vend);
        if (after_vend != '0) begin
          state_nxt  = S_PAYOUT;
          gap_nxt    = '0;
          dime_nxt   = (after_vend >= SW'(2));
          nickel_nxt = (after_vend <  SW'(2));
        end else begin
          state_nxt = S_IDLE;
        end
      end

      // gap_cnt == 0 is the pulse cycle; 1..PAY_GAP are the quiet cycles after it.
      S_PAYOUT: begin
        if (gap_cnt == '0) begin
          credit_nxt = (SW'(credit) >= SW'(2)) ? credit - CW'(2) : credit - CW'(1);
          gap_nxt    = GW'(1);
        end else if (gap_cnt == GW'(PAY_GAP)) begin
          gap_nxt = '0;
          if (credit != '0) begin
            dime_nxt   = (SW'(credit) >= SW'(2));
            nickel_nxt = (SW'(credit) <  SW'(2));
          end else begin
            state_nxt = S_IDLE;
          end
        end else begin
          gap_nxt = gap_cnt + GW'(1);
        end
      end

      default: state_nxt = S_IDLE;
    endcase

    busy_nxt = (state_nxt != S_IDLE);
  end

endmodule

// File: tb/tb_vend_coin_ctrl.sv
// Scoreboard bench for vend_coin_ctrl: directed coin/refund sequences queue expected
// pulse events (kind, credit, cycle); a negedge monitor matches them as the DUTs emit pulses.
module tb_vend_coin_ctrl;

  localparam int unsigned CW = 5;
  localparam logic [3:0] EV_DISP = 4'b1000;
  localparam logic [3:0] EV_REJ  = 4'b0100;
  localparam logic [3:0] EV_DIME = 4'b0010;
  localparam logic [3:0] EV_NICK = 4'b0001;
  localparam logic [1:0] NICK = 2'b01;
  localparam logic [1:0] DIME = 2'b10;
  localparam logic [1:0] QTR  = 2'b11;

  typedef struct packed {
    logic [3:0]    ev;
    logic [CW-1:0] cred;
    int            cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic          coin_valid_a = 1'b0, coin_valid_b = 1'b0;
  logic [1:0]    coin_type_a = 2'b00, coin_type_b = 2'b00;
  logic          refund_a = 1'b0, refund_b = 1'b0;
  logic          coin_ready_a, coin_ready_b;
  logic          disp_a, disp_b, rej_a, rej_b, dime_a, dime_b, nick_a, nick_b;
  logic          busy_a, busy_b;
  logic [CW-1:0] credit_a, credit_b;

  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;
  exp_t q_a[$];
  exp_t q_b[$];

  vend_coin_ctrl dut_a (
    .clk(clk), .rst_n(rst_n),
    .coin_valid(coin_valid_a), .coin_type(coin_type_a), .coin_ready(coin_ready_a),
    .refund_req(refund_a), .dispense(disp_a), .coin_reject(rej_a),
    .pay_dime(dime_a), .pay_nickel(nick_a), .credit(credit_a), .busy(busy_a)
  );

  vend_coin_ctrl #(.PRICE(20), .MAX_CREDIT(20)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .coin_valid(coin_valid_b), .coin_type(coin_type_b), .coin_ready(coin_ready_b),
    .refund_req(refund_b), .dispense(disp_b), .coin_reject(rej_b),
    .pay_dime(dime_b), .pay_nickel(nick_b), .credit(credit_b), .busy(busy_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic exp_t mk(input logic [3:0] ev, input int cr, input int cy);
    exp_t e;
    e.ev   = ev;
    e.cred = CW'(cr);
    e.cyc  = cy;
    return e;
  endfunction

  task automatic check(input string nm, input int act, input int req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, req);
  endtask

  task automatic sb_check(input string nm, input logic have, input exp_t e,
                          input logic [3:0] o, input logic [CW-1:0] c);
    n_total++;
    if (!have)
      $display("FAIL %s unexpected event: got ev=%b credit=%0d cycle=%0d, expected none", nm, o, c, cyc);
    else if (o == e.ev && c == e.cred && e.cyc == cyc)
      n_pass++;
    else
      $display("FAIL %s event: got ev=%b credit=%0d cycle=%0d, expected ev=%b credit=%0d cycle=%0d",
               nm, o, c, cyc, e.ev, e.cred, e.cyc);
  endtask

  // Monitor: any pulse on either DUT consumes the oldest expected event of that DUT.
  always @(negedge clk) begin
    logic [3:0] oa, ob;
    oa = {disp_a, rej_a, dime_a, nick_a};
    ob = {disp_b, rej_b, dime_b, nick_b};
    if (oa != 4'b0000) begin
      if (q_a.size() == 0) sb_check("dut_a", 1'b0, mk(4'b0000, 0, -1), oa, credit_a);
      else                 sb_check("dut_a", 1'b1, q_a.pop_front(), oa, credit_a);
    end
    if (ob != 4'b0000) begin
      if (q_b.size() == 0) sb_check("dut_b", 1'b0, mk(4'b0000, 0, -1), ob, credit_b);
      else                 sb_check("dut_b", 1'b1, q_b.pop_front(), ob, credit_b);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Offers one coin until accepted; c is the cycle in which the handshake happened.
  task automatic push(input bit sel, input logic [1:0] t, output int c);
    bit ok;
    ok = 1'b0;
    if (sel) begin coin_valid_b = 1'b1; coin_type_b = t; end
    else     begin coin_valid_a = 1'b1; coin_type_a = t; end
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (sel ? coin_ready_b : coin_ready_a) begin
        ok = 1'b1;
        break;
      end
    end
    c = cyc;
    @(posedge clk);
    #1;
    coin_valid_a = 1'b0;
    coin_valid_b = 1'b0;
    if (!ok) check("push_accept_timeout", 0, 1);
  endtask

  initial begin
    int c0, c1, c2, c3, c4, c5, r;

    // Reset
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset_pulses_a", int'({disp_a, rej_a, dime_a, nick_a}), 0);
    check("reset_credit_a", int'(credit_a), 0);
    check("reset_ready_a", int'(coin_ready_a), 1);
    check("reset_busy_a", int'(busy_a), 0);
    check("reset_credit_b", int'(credit_b), 0);
    @(posedge clk); #1;

    // Exact pay with three nickels
    push(1'b0, NICK, c0);
    push(1'b0, NICK, c1);
    push(1'b0, NICK, c2);
    q_a.push_back(mk(EV_DISP, 3, c2 + 2));
    step(6);
    @(negedge clk);
    check("exact_credit", int'(credit_a), 0);
    check("exact_busy", int'(busy_a), 0);
    @(posedge clk); #1;

    // Quarter: dispense then one dime of change
    push(1'b0, QTR, c0);
    q_a.push_back(mk(EV_DISP, 5, c0 + 2));
    q_a.push_back(mk(EV_DIME, 2, c0 + 3));
    step(8);
    @(negedge clk);
    check("quarter_credit", int'(credit_a), 0);
    @(posedge clk); #1;

    // Nickel + quarter: change of 3 is a dime then a nickel, two quiet cycles apart
    push(1'b0, NICK, c0);
    push(1'b0, QTR, c1);
    q_a.push_back(mk(EV_DISP, 6, c1 + 2));
    q_a.push_back(mk(EV_DIME, 3, c1 + 3));
    q_a.push_back(mk(EV_NICK, 1, c1 + 6));
    step(10);
    @(negedge clk);
    check("change_credit", int'(credit_a), 0);
    check("change_busy", int'(busy_a), 0);
    @(posedge clk); #1;

    // Refund of a dime
    push(1'b0, DIME, c0);
    step(2);
    @(negedge clk);
    check("refund_credit_before", int'(credit_a), 2);
    @(posedge clk); #1;
    refund_a = 1'b1;
    r = cyc;
    q_a.push_back(mk(EV_DIME, 2, r + 1));
    step(1);
    refund_a = 1'b0;
    step(5);
    @(negedge clk);
    check("refund_credit_after", int'(credit_a), 0);
    check("refund_busy", int'(busy_a), 0);
    @(posedge clk); #1;

    // Refund wins over a queued coin; the coin is credited afterwards
    push(1'b0, NICK, c0);
    step(2);
    push(1'b0, DIME, c1);
    refund_a = 1'b1;
    r = cyc;
    q_a.push_back(mk(EV_NICK, 1, r + 1));
    step(1);
    refund_a = 1'b0;
    step(6);
    @(negedge clk);
    check("refund_then_coin_credit", int'(credit_a), 2);
    check("refund_then_coin_busy", int'(busy_a), 0);
    @(posedge clk); #1;

    // Backpressure: five nickels offered during a two-dime payout
    push(1'b0, QTR, c0);
    q_a.push_back(mk(EV_DISP, 7, c0 + 2));
    q_a.push_back(mk(EV_DIME, 4, c0 + 3));
    q_a.push_back(mk(EV_DIME, 2, c0 + 6));
    q_a.push_back(mk(EV_DISP, 3, c0 + 12));
    step(2);
    push(1'b0, NICK, c1);
    push(1'b0, NICK, c2);
    push(1'b0, NICK, c3);
    push(1'b0, NICK, c4);
    push(1'b0, NICK, c5);
    check("bp_fourth_accept_cycle", c4 - c0, 6);
    check("bp_fifth_accept_cycle", c5 - c0, 10);
    step(6);
    @(negedge clk);
    check("bp_credit", int'(credit_a), 2);
    check("bp_busy", int'(busy_a), 0);
    @(posedge clk); #1;
    refund_a = 1'b1;
    r = cyc;
    q_a.push_back(mk(EV_DIME, 2, r + 1));
    step(1);
    refund_a = 1'b0;
    step(5);
    @(negedge clk);
    check("bp_cleanup_credit", int'(credit_a), 0);
    @(posedge clk); #1;

    // Reject at the credit ceiling (PRICE = MAX_CREDIT = 20)
    push(1'b1, DIME, c0);
    push(1'b1, DIME, c1);
    push(1'b1, QTR, c2);
    push(1'b1, QTR, c3);
    push(1'b1, QTR, c4);
    push(1'b1, QTR, c5);
    q_b.push_back(mk(EV_REJ, 19, c5 + 2));
    step(4);
    @(negedge clk);
    check("reject_credit", int'(credit_b), 19);
    check("reject_busy", int'(busy_b), 0);
    @(posedge clk); #1;

    // Reset asserted in the middle of a refund payout
    refund_b = 1'b1;
    r = cyc;
    q_b.push_back(mk(EV_DIME, 19, r + 1));
    q_b.push_back(mk(EV_DIME, 17, r + 4));
    step(1);
    refund_b = 1'b0;
    step(4);
    rst_n = 1'b0;
    @(negedge clk);
    check("midreset_pulses", int'({dime_b, nick_b}), 0);
    check("midreset_credit", int'(credit_b), 0);
    check("midreset_busy", int'(busy_b), 0);
    @(posedge clk); #1;
    step(3);
    rst_n = 1'b1;
    step(10);
    @(negedge clk);
    check("post_reset_credit_b", int'(credit_b), 0);
    check("post_reset_busy_b", int'(busy_b), 0);
    check("post_reset_ready_b", int'(coin_ready_b), 1);

    check("events_left_a", q_a.size(), 0);
    check("events_left_b", q_b.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
